midi_tx_sched: RTL and testbench

MIDI_TX_SCHED -- requirements
Module: midi_tx_sched

---
 rtl/midi_pkg.sv | 55 +++++
 rtl/midi_rr_arbiter.sv | 52 +++++
 rtl/midi_tx_sched.sv | 153 +++++++++++++++
 tb/tb_midi_tx_sched.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// Shared MIDI scheduler definitions: FSM states, status-byte range constants
// and the status-to-message-length decode used by the transmit scheduler.
package midi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND_ST,
        SEND_D1,
        SEND_D2,
        DONE
    } midi_state_e;

    localparam logic [7:0] ST_VOICE_LO  = 8'h80;
    localparam logic [7:0] ST_3B_HI     = 8'hBF;
    localparam logic [7:0] ST_2B_LO     = 8'hC0;
    localparam logic [7:0] ST_2B_HI     = 8'hDF;
    localparam logic [7:0] ST_BEND_LO   = 8'hE0;
    localparam logic [7:0] ST_VOICE_HI  = 8'hEF;
    localparam logic [7:0] ST_SYSCOM_LO = 8'hF0;
    localparam logic [7:0] ST_SYSCOM_HI = 8'hF7;
    localparam logic [7:0] ST_MTC_QF    = 8'hF1;
    localparam logic [7:0] ST_SONG_POS  = 8'hF2;
    localparam logic [7:0] ST_SONG_SEL  = 8'hF3;

    localparam logic [1:0] LEN_1 = 2'd1;
    localparam logic [1:0] LEN_2 = 2'd2;
    localparam logic [1:0] LEN_3 = 2'd3;

    function automatic logic midi_is_voice(input logic [7:0] st);
        return (st >= ST_VOICE_LO) && (st <= ST_VOICE_HI);
    endfunction

    function automatic logic midi_is_syscom(input logic [7:0] st);
        return (st >= ST_SYSCOM_LO) && (st <= ST_SYSCOM_HI);
    endfunction

    // Data bytes (< 0x80) and undefined system bytes travel alone.
    function automatic logic [1:0] midi_msg_len(input logic [7:0] st);
        logic [1:0] len;
        len = LEN_1;
        if ((st >= ST_VOICE_LO) && (st <= ST_3B_HI)) begin
            len = LEN_3;
        end else if ((st >= ST_2B_LO) && (st <= ST_2B_HI)) begin
            len = LEN_2;
        end else if ((st >= ST_BEND_LO) && (st <= ST_VOICE_HI)) begin
            len = LEN_3;
        end else if (st == ST_SONG_POS) begin
            len = LEN_3;
        end else if ((st == ST_MTC_QF) || (st == ST_SONG_SEL)) begin
            len = LEN_2;
        end
        return len;
    endfunction

endpackage

// File: rtl/midi_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching from last winner + 1.
// Zero latency to grant; pointer moves only when the grant is taken (i_take).
module midi_rr_arbiter #(
    parameter int N_REQ = 4,
    localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_take,
    output logic [N_REQ-1:0] o_grant,
    output logic [IW-1:0]    o_grant_idx,
    output logic             o_grant_vld
);

    logic [IW-1:0]    r_last;
    logic [IW-1:0]    w_cand;
    logic [IW-1:0]    w_idx;
    logic             w_found;
    logic [N_REQ-1:0] w_grant;

    always_comb begin
        w_cand  = '0;
        w_idx   = '0;
        w_found = 1'b0;
        w_grant = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand = IW'((int'(r_last) + k) % N_REQ);
            if (!w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
        if (w_found) begin
            w_grant[w_idx] = 1'b1;
        end
    end

    // Reset to the top index so requester 0 is searched first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last <= IW'(N_REQ - 1);
        end else if (i_take && w_found) begin
            r_last <= w_idx;
        end
    end

    assign o_grant     = w_grant;
    assign o_grant_idx = w_idx;
    assign o_grant_vld = w_found;

endmodule

// File: rtl/midi_tx_sched.sv
// Schedules N_REQ MIDI message requesters onto one UART byte stream, with running status.
// First byte valid 1 clk after grant; tx_data/tx_valid hold while tx_ready is low.
module midi_tx_sched
    import midi_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int RUNNING_STATUS = 1,
    localparam int IW            = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ-1:0][7:0] msg_status,
    input  logic [N_REQ-1:0][7:0] msg_d1,
    input  logic [N_REQ-1:0][7:0] msg_d2,
    output logic [N_REQ-1:0]      ack,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy
);

    midi_state_e r_state;
    midi_state_e w_state_nxt;

    logic [7:0]       r_st;
    logic [7:0]       r_d1;
    logic [7:0]       r_d2;
    logic [IW-1:0]    r_idx;
    logic [1:0]       r_len;
    logic [7:0]       r_rs;
    logic             r_rs_vld;

    logic [N_REQ-1:0] w_grant;
    logic [IW-1:0]    w_grant_idx;
    logic             w_grant_vld;
    logic             w_take;
    logic             w_accept;
    logic [7:0]       w_sel_st;
    logic             w_skip_st;

    midi_rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_arb (
        .clk        (clk),
        .rst        (rst),
        .i_req      (req),
        .i_take     (w_take),
        .o_grant    (w_grant),
        .o_grant_idx(w_grant_idx),
        .o_grant_vld(w_grant_vld)
    );

    assign w_take    = (r_state == IDLE) && w_grant_vld;
    assign w_accept  = tx_valid && tx_ready;
    assign w_sel_st  = msg_status[w_grant_idx];
    // Running status only ever holds a voice status, the voice check guards stray matches.
    assign w_skip_st = (RUNNING_STATUS != 0) && r_rs_vld && (r_rs == w_sel_st)
                       && midi_is_voice(w_sel_st);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_take) begin
                    w_state_nxt = w_skip_st ? SEND_D1 : SEND_ST;
                end
            end
            SEND_ST: begin
                if (w_accept) begin
                    w_state_nxt = (r_len == LEN_1) ? DONE : SEND_D1;
                end
            end
            SEND_D1: begin
                if (w_accept) begin
                    w_state_nxt = (r_len == LEN_3) ? SEND_D2 : DONE;
                end
            end
            SEND_D2: begin
                if (w_accept) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_st  <= '0;
            r_d1  <= '0;
            r_d2  <= '0;
            r_idx <= '0;
            r_len <= LEN_1;
        end else if (w_take) begin
            r_st  <= w_sel_st;
            r_d1  <= msg_d1[w_grant_idx];
            r_d2  <= msg_d2[w_grant_idx];
            r_idx <= w_grant_idx;
            r_len <= midi_msg_len(w_sel_st);
        end
    end

    // System common cancels running status; realtime bytes pass through it untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rs     <= '0;
            r_rs_vld <= 1'b0;
        end else if ((r_state == SEND_ST) && w_accept) begin
            if (midi_is_voice(r_st)) begin
                r_rs     <= r_st;
                r_rs_vld <= 1'b1;
            end else if (midi_is_syscom(r_st)) begin
                r_rs     <= '0;
                r_rs_vld <= 1'b0;
            end
        end
    end

    always_comb begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        ack      = '0;
        case (r_state)
            SEND_ST: begin
                tx_valid = 1'b1;
                tx_data  = r_st;
            end
            SEND_D1: begin
                tx_valid = 1'b1;
                tx_data  = r_d1;
            end
            SEND_D2: begin
                tx_valid = 1'b1;
                tx_data  = r_d2;
            end
            DONE:    ack[r_idx] = 1'b1;
            default: ;
        endcase
    end

    assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_midi_tx_sched.sv
// Self-checking bench for midi_tx_sched against a byte-sequence reference model.
module tb_midi_tx_sched;

    localparam int N = 4;
    typedef logic [7:0] bq_t[$];

    logic              clk;
    logic              rst;
    logic [N-1:0]      req;
    logic [N-1:0]      req_b;
    logic [N-1:0][7:0] msg_status;
    logic [N-1:0][7:0] msg_d1;
    logic [N-1:0][7:0] msg_d2;
    logic [N-1:0]      ack;
    logic [N-1:0]      ack_b;
    logic [7:0]        tx_data;
    logic [7:0]        tx_data_b;
    logic              tx_valid;
    logic              tx_valid_b;
    logic              tx_ready;
    logic              busy;
    logic              busy_b;

    int n_checks = 0;
    int n_fail   = 0;
    int model_rs = -1;

    midi_tx_sched #(.N_REQ(N), .RUNNING_STATUS(1)) dut (
        .clk(clk), .rst(rst), .req(req),
        .msg_status(msg_status), .msg_d1(msg_d1), .msg_d2(msg_d2),
        .ack(ack), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy)
    );

    midi_tx_sched #(.N_REQ(N), .RUNNING_STATUS(0)) dut_nors (
        .clk(clk), .rst(rst), .req(req_b),
        .msg_status(msg_status), .msg_d1(msg_d1), .msg_d2(msg_d2),
        .ack(ack_b), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
        .tx_ready(tx_ready), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int spec_len(input logic [7:0] s);
        if (s < 8'h80) return 1;
        if (s <= 8'hBF) return 3;
        if (s <= 8'hDF) return 2;
        if (s <= 8'hEF) return 3;
        if (s == 8'hF2) return 3;
        if (s == 8'hF1 || s == 8'hF3) return 2;
        return 1;
    endfunction

    // Expected byte stream for one message and the running status it leaves behind.
    task automatic model_msg(input bit rs_en, input int rs_in, input logic [7:0] s,
                             input logic [7:0] d1, input logic [7:0] d2,
                             output int rs_out, output bq_t q);
        int  n;
        bit  voice;
        n     = spec_len(s);
        voice = (s >= 8'h80) && (s <= 8'hEF);
        q     = {};
        if (!(rs_en && voice && (rs_in == int'(s)))) q.push_back(s);
        if (n >= 2) q.push_back(d1);
        if (n == 3) q.push_back(d2);
        if (voice) rs_out = int'(s);
        else if (s >= 8'hF0 && s <= 8'hF7) rs_out = -1;
        else rs_out = rs_in;
    endtask

    function automatic bit q_eq(input bq_t a, input bq_t b);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic string q_str(input bq_t q);
        string s;
        s = "";
        foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
        return s;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0; req = '0; req_b = '0; tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
    endtask

    // Drives one request and records every accepted byte until its ack.
    task automatic send_capture(input bit use_b, input int idx, input logic [7:0] s,
                                input logic [7:0] d1, input logic [7:0] d2, input int rdy_pct,
                                output bq_t got, output int first_cyc, output int ack_cyc,
                                output int ack_idx, output bit timed_out);
        logic [N-1:0] ak;
        logic         tv;
        logic [7:0]   td;
        got = {}; first_cyc = -1; ack_cyc = -1; ack_idx = -1; timed_out = 1'b1;
        msg_status[idx] = s; msg_d1[idx] = d1; msg_d2[idx] = d2;
        if (use_b) req_b[idx] = 1'b1; else req[idx] = 1'b1;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(posedge clk); #1;
            ak = use_b ? ack_b : ack;
            tv = use_b ? tx_valid_b : tx_valid;
            td = use_b ? tx_data_b : tx_data;
            if (ak != '0) begin
                ack_cyc = cyc;
                for (int k = 0; k < N; k++) if (ak[k]) ack_idx = k;
                timed_out = 1'b0;
                break;
            end
            if (tv) begin
                if (first_cyc < 0) first_cyc = cyc;
                tx_ready = ($urandom_range(99) < rdy_pct);
                if (tx_ready) got.push_back(td);
            end else begin
                tx_ready = 1'($urandom_range(1));
            end
        end
        req[idx] = 1'b0; req_b[idx] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; req = '0; req_b = '0; tx_ready = 1'b0;
        msg_status = '0; msg_d1 = '0; msg_d2 = '0;
        #1;
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
        n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data got=%02h exp=00", tx_data); end
        n_checks++; if (ack !== '0) begin n_fail++; $display("FAIL reset_ack got=%b exp=0000", ack); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        bq_t got, exp;
        int  fc, ac, ai;
        bit  to;
        model_msg(1'b1, model_rs, 8'h90, 8'h3C, 8'h7F, model_rs, exp);
        send_capture(1'b0, 0, 8'h90, 8'h3C, 8'h7F, 100, got, fc, ac, ai, to);
        n_checks++; if (!q_eq(got, exp)) begin n_fail++; $display("FAIL basic_bytes got=%s exp=%s", q_str(got), q_str(exp)); end
        n_checks++; if (fc != 1) begin n_fail++; $display("FAIL basic_latency got=%0d exp=1", fc); end
        n_checks++; if (ac != 4 || to) begin n_fail++; $display("FAIL basic_ack_cycle got=%0d exp=4", ac); end
        n_checks++; if (ai != 0) begin n_fail++; $display("FAIL basic_ack_idx got=%0d exp=0", ai); end
        @(posedge clk); #1;
        n_checks++; if (ack !== '0 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_ack_width ack=%b busy=%b exp=0000/0", ack, busy); end
    endtask

    task automatic test_running_status();
        bq_t got, exp, want;
        int  fc, ac, ai;
        bit  to;
        model_msg(1'b1, model_rs, 8'h90, 8'h40, 8'h64, model_rs, exp);
        send_capture(1'b0, 1, 8'h90, 8'h40, 8'h64, 100, got, fc, ac, ai, to);
        n_checks++; if (!q_eq(got, exp) || ai != 1) begin n_fail++; $display("FAIL rs_first got=%s idx=%0d exp=%s idx=1", q_str(got), ai, q_str(exp)); end
        @(posedge clk); #1;
        model_msg(1'b1, model_rs, 8'h90, 8'h40, 8'h00, model_rs, exp);
        want = '{8'h40, 8'h00};
        send_capture(1'b0, 1, 8'h90, 8'h40, 8'h00, 100, got, fc, ac, ai, to);
        n_checks++; if (!q_eq(got, want) || !q_eq(got, exp)) begin n_fail++; $display("FAIL rs_suppressed got=%s exp=%s", q_str(got), q_str(want)); end
        @(posedge clk); #1;
    endtask

    task automatic test_no_running_status();
        bq_t got, want;
        int  fc, ac, ai;
        bit  to;
        want = '{8'h90, 8'h40, 8'h64};
        send_capture(1'b1, 1, 8'h90, 8'h40, 8'h64, 100, got, fc, ac, ai, to);
        n_checks++; if (!q_eq(got, want) || ai != 1) begin n_fail++; $display("FAIL nors_first got=%s exp=%s", q_str(got), q_str(want)); end
        @(posedge clk); #1;
        want = '{8'h90, 8'h40, 8'h00};
        send_capture(1'b1, 1, 8'h90, 8'h40, 8'h00, 100, got, fc, ac, ai, to);
        n_checks++; if (!q_eq(got, want)) begin n_fail++; $display("FAIL nors_second got=%s exp=%s", q_str(got), q_str(want)); end
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        int n_ack, last_cyc, idx;
        do_reset();
        model_rs = -1;
        for (int i = 0; i < N; i++) begin
            msg_status[i] = 8'hF8 + 8'(i); msg_d1[i] = 8'h00; msg_d2[i] = 8'h00;
        end
        tx_ready = 1'b1;
        req = '1;
        n_ack = 0; last_cyc = 0;
        for (int cyc = 1; cyc <= 100 && n_ack < 5; cyc++) begin
            @(posedge clk); #1;
            if (ack != '0) begin
                idx = -1;
                for (int k = 0; k < N; k++) if (ack[k]) idx = k;
                n_checks++; if ($countones(ack) != 1 || idx != (n_ack % N)) begin n_fail++; $display("FAIL rr_order[%0d] got=%b exp_idx=%0d", n_ack, ack, n_ack % N); end
                n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rr_valid_in_done got=%b exp=0", tx_valid); end
                if (n_ack > 0) begin
                    n_checks++; if (cyc - last_cyc != 3) begin n_fail++; $display("FAIL rr_spacing got=%0d exp=3", cyc - last_cyc); end
                end
                last_cyc = cyc;
                n_ack++;
                if (n_ack == 5) req = '0;
            end
        end
        req = '0;
        n_checks++; if (n_ack != 5) begin n_fail++; $display("FAIL rr_ack_count got=%0d exp=5", n_ack); end
        repeat (4) @(posedge clk); #1;
    endtask

    task automatic test_stall();
        bq_t exp;
        bit  bad;
        model_msg(1'b1, model_rs, 8'hC5, 8'h07, 8'h00, model_rs, exp);
        msg_status[2] = 8'hC5; msg_d1[2] = 8'h07; msg_d2[2] = 8'hAA;
        tx_ready = 1'b0;
        req[2] = 1'b1;
        @(posedge clk); #1;
        msg_status[2] = 8'h33; msg_d1[2] = 8'h44;
        for (int k = 0; k < 5; k++) begin
            n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hC5 || busy !== 1'b1) begin n_fail++; $display("FAIL stall_hold[%0d] valid=%b data=%02h exp=1/c5", k, tx_valid, tx_data); end
            @(posedge clk); #1;
        end
        tx_ready = 1'b1;
        n_checks++; if (tx_data !== 8'hC5) begin n_fail++; $display("FAIL stall_release got=%02h exp=c5", tx_data); end
        @(posedge clk); #1;
        n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h07) begin n_fail++; $display("FAIL stall_d1 valid=%b got=%02h exp=07", tx_valid, tx_data); end
        @(posedge clk); #1;
        bad = (ack !== 4'b0100) || (tx_valid !== 1'b0) || (exp.size() != 2);
        n_checks++; if (bad) begin n_fail++; $display("FAIL stall_ack got=%b exp=0100", ack); end
        req[2] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_realtime();
        bq_t got, exp, want;
        int  fc, ac, ai;
        bit  to;
        logic [7:0] sts [4];
        sts[0] = 8'hF8; sts[1] = 8'h90; sts[2] = 8'hF6; sts[3] = 8'h90;
        model_msg(1'b1, model_rs, 8'h90, 8'h3C, 8'h40, model_rs, exp);
        send_capture(1'b0, 3, 8'h90, 8'h3C, 8'h40, 70, got, fc, ac, ai, to);
        n_checks++; if (!q_eq(got, exp) || to) begin n_fail++; $display("FAIL rt_prime got=%s exp=%s", q_str(got), q_str(exp)); end
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: want = '{8'hF8};
                1: want = '{8'h3C, 8'h40};
                2: want = '{8'hF6};
                default: want = '{8'h90, 8'h3C, 8'h40};
            endcase
            model_msg(1'b1, model_rs, sts[i], 8'h3C, 8'h40, model_rs, exp);
            send_capture(1'b0, 3, sts[i], 8'h3C, 8'h40, 70, got, fc, ac, ai, to);
            n_checks++; if (!q_eq(got, want) || !q_eq(got, exp)) begin n_fail++; $display("FAIL rt_step[%0d] got=%s exp=%s", i, q_str(got), q_str(want)); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        bq_t got, want;
        int  fc, ac, ai;
        bit  to, saw_ack;
        msg_status[0] = 8'hB0; msg_d1[0] = 8'h07; msg_d2[0] = 8'h55;
        tx_ready = 1'b1;
        req[0] = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (tx_data !== 8'hB0) begin n_fail++; $display("FAIL rmid_status got=%02h exp=b0", tx_data); end
        @(posedge clk); #1;
        tx_ready = 1'b0;
        n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h07) begin n_fail++; $display("FAIL rmid_d1 valid=%b got=%02h exp=07", tx_valid, tx_data); end
        rst = 1'b0;
        #1;
        n_checks++; if (tx_valid !== 1'b0 || ack !== '0 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_async valid=%b ack=%b busy=%b exp=0", tx_valid, ack, busy); end
        req[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        model_rs = -1;
        saw_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (ack != '0) saw_ack = 1'b1;
        end
        n_checks++; if (saw_ack) begin n_fail++; $display("FAIL rmid_no_ack got=1 exp=0"); end
        want = '{8'hB0, 8'h07, 8'h55};
        send_capture(1'b0, 0, 8'hB0, 8'h07, 8'h55, 100, got, fc, ac, ai, to);
        n_checks++; if (!q_eq(got, want) || ai != 0) begin n_fail++; $display("FAIL rmid_resend got=%s exp=%s", q_str(got), q_str(want)); end
        model_rs = 8'hB0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        bq_t got, exp;
        int  fc, ac, ai, idx, sel;
        bit  to;
        logic [7:0] s, d1, d2;
        logic [7:0] voices [6];
        voices[0] = 8'h90; voices[1] = 8'h80; voices[2] = 8'hB3;
        voices[3] = 8'hC5; voices[4] = 8'hD2; voices[5] = 8'hE1;
        for (int t = 0; t < 40; t++) begin
            idx = $urandom_range(N - 1);
            sel = $urandom_range(9);
            if (sel < 6) s = voices[$urandom_range(5)];
            else if (sel == 6) s = 8'hF0 + 8'($urandom_range(15));
            else if (sel == 7) s = 8'($urandom_range(127));
            else s = 8'($urandom_range(255));
            d1 = 8'($urandom_range(127));
            d2 = 8'($urandom_range(127));
            model_msg(1'b1, model_rs, s, d1, d2, model_rs, exp);
            send_capture(1'b0, idx, s, d1, d2, 60, got, fc, ac, ai, to);
            n_checks++; if (to || ai != idx || !q_eq(got, exp)) begin n_fail++; $display("FAIL random[%0d] st=%02h got=%s idx=%0d exp=%s idx=%0d", t, s, q_str(got), ai, q_str(exp), idx); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_running_status();
        test_no_running_status();
        test_round_robin();
        test_stall();
        test_realtime();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
